reg_write_arbiter: RTL

//  Sole driver of the register file write port (control_reg_write, control_write_id, reg_write_value).

---
 rtl/reg_write_arbiter_pkg.sv | 14 +
 rtl/reg_write_arbiter_write_queue.sv | 87 ++++++++
 rtl/reg_write_arbiter.sv | 81 ++++++++
 3 files changed

// File: rtl/reg_write_arbiter_pkg.sv
// Shared widths and the queued-write payload for the register file write arbiter.
package reg_write_arbiter_pkg;

    localparam int unsigned REG_ID_W = 5;
    localparam int unsigned WORD_W   = 32;
    localparam logic [REG_ID_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic                live;
        logic [REG_ID_W-1:0] id;
        logic [WORD_W-1:0]   value;
    } q_entry_t;

endpackage

// File: rtl/reg_write_arbiter_write_queue.sv
// Circular buffer of pending aux register writes with kill-by-id and pending lookups.
module write_queue
    import reg_write_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                push,
    input  logic [REG_ID_W-1:0] push_id,
    input  logic [WORD_W-1:0]   push_value,
    input  logic                pop,
    input  logic                kill_valid,
    input  logic [REG_ID_W-1:0] kill_id,
    input  logic [REG_ID_W-1:0] rs_id,
    input  logic [REG_ID_W-1:0] rt_id,
    output logic                head_live,
    output logic [REG_ID_W-1:0] head_id,
    output logic [WORD_W-1:0]   head_value,
    output logic                empty,
    output logic                full,
    output logic                rs_hit,
    output logic                rt_hit
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    q_entry_t           mem [DEPTH];
    logic [PTR_W-1:0]   head_ptr;
    logic [PTR_W-1:0]   tail_ptr;
    logic [CNT_W-1:0]   count;
    logic               push_live;

    // A result accepted on the same edge as a younger writeback to the same register is born dead.
    assign push_live = ~(kill_valid && (kill_id == push_id));

    assign empty      = (count == CNT_W'(0));
    assign full       = (count == CNT_W'(DEPTH));
    assign head_live  = mem[head_ptr].live;
    assign head_id    = mem[head_ptr].id;
    assign head_value = mem[head_ptr].value;

    // live bits are cleared on pop, so a set live bit always marks an occupied slot
    always_ff @(posedge clock) begin
        if (reset) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[PTR_W'(i)].live <= 1'b0;
            end
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (kill_valid && (mem[PTR_W'(i)].id == kill_id)) begin
                    mem[PTR_W'(i)].live <= 1'b0;
                end
            end
            if (pop && !empty) begin
                mem[head_ptr].live <= 1'b0;
                head_ptr           <= head_ptr + PTR_W'(1);
            end
            if (push && !full) begin
                mem[tail_ptr] <= '{live: push_live, id: push_id, value: push_value};
                tail_ptr      <= tail_ptr + PTR_W'(1);
            end
            case ({push && !full, pop && !empty})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Pending lookups over live entries; register 0 is never reported.
    always_comb begin
        rs_hit = 1'b0;
        rt_hit = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (mem[PTR_W'(i)].live && (mem[PTR_W'(i)].id == rs_id)) rs_hit = 1'b1;
            if (mem[PTR_W'(i)].live && (mem[PTR_W'(i)].id == rt_id)) rt_hit = 1'b1;
        end
        if (rs_id == REG_ZERO) rs_hit = 1'b0;
        if (rt_id == REG_ZERO) rt_hit = 1'b0;
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Sole driver of the register file write port: writeback has priority, aux results drain from a queue.
module reg_write_arbiter
    import reg_write_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wb_valid,
    input  logic [4:0]  wb_write_id,
    input  logic [31:0] wb_value,
    input  logic        aux_valid,
    output logic        aux_ready,
    input  logic [4:0]  aux_write_id,
    input  logic [31:0] aux_value,
    input  logic [4:0]  reg_rs_id,
    input  logic [4:0]  reg_rt_id,
    output logic        rs_pending,
    output logic        rt_pending,
    output logic        control_reg_write,
    output logic [4:0]  control_write_id,
    output logic [31:0] reg_write_value
);

    logic                wb_write;
    logic                aux_push;
    logic                q_pop;
    logic                q_empty;
    logic                q_full;
    logic                head_live;
    logic [REG_ID_W-1:0] head_id;
    logic [WORD_W-1:0]   head_value;

    assign wb_write  = wb_valid && (wb_write_id != REG_ZERO);
    // Ready depends only on registered occupancy; held low while reset is asserted.
    assign aux_ready = ~reset & ~q_full;
    assign aux_push  = aux_valid && aux_ready && (aux_write_id != REG_ZERO);
    assign q_pop     = ~wb_write & ~q_empty;

    write_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clock      (clock),
        .reset      (reset),
        .push       (aux_push),
        .push_id    (aux_write_id),
        .push_value (aux_value),
        .pop        (q_pop),
        .kill_valid (wb_write),
        .kill_id    (wb_write_id),
        .rs_id      (reg_rs_id),
        .rt_id      (reg_rt_id),
        .head_live  (head_live),
        .head_id    (head_id),
        .head_value (head_value),
        .empty      (q_empty),
        .full       (q_full),
        .rs_hit     (rs_pending),
        .rt_hit     (rt_pending)
    );

    // Port registers; id/value hold when no write is issued.
    always_ff @(posedge clock) begin
        if (reset) begin
            control_reg_write <= 1'b0;
            control_write_id  <= REG_ZERO;
            reg_write_value   <= '0;
        end else if (wb_write) begin
            control_reg_write <= 1'b1;
            control_write_id  <= wb_write_id;
            reg_write_value   <= wb_value;
        end else if (q_pop) begin
            control_reg_write <= head_live;
            control_write_id  <= head_id;
            reg_write_value   <= head_value;
        end else begin
            control_reg_write <= 1'b0;
        end
    end

endmodule
